// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus bit-serial shifts,
// returning one registered result per request under a valid/ready handshake.
module alu_exec_unit #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic             shl;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             slt_bit;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] acc_nxt;

  // Handshake: a request moves when op_valid && op_ready; a result moves when
  // res_valid && res_ready. op_ready depends only on state and res_ready, so a
  // held result frees the unit in the same cycle the consumer takes it.
  assign op_ready = (state == ST_IDLE) || ((state == ST_DONE) && res_ready);
  assign accept   = op_valid && op_ready;
  assign shamt    = b[SHW-1:0];
  assign is_shift = (operation == OP_SLL) || (operation == OP_SRL);
  assign slt_bit  = $signed(a) < $signed(b);
  assign acc_nxt  = shl ? (acc << 1) : (acc >> 1);

  // Result for everything that finishes in one cycle, including zero-length shifts.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (operation)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLL:  alu_res = a;
      OP_SRL:  alu_res = a;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      shl       <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      // Reached from IDLE or from DONE while the current result is consumed.
      if (is_shift && (shamt != '0)) begin
        acc       <= a;
        cnt       <= shamt;
        shl       <= (operation == OP_SLL);
        state     <= ST_SHIFT;
        res_valid <= 1'b0;
      end else begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        illegal   <= alu_ill;
        state     <= ST_DONE;
        res_valid <= 1'b1;
      end
    end else begin
      case (state)
        ST_SHIFT: begin
          // The last shift step writes straight into the result register.
          if (cnt == {{(SHW-1){1'b0}}, 1'b1}) begin
            result    <= acc_nxt;
            zero      <= (acc_nxt == '0);
            illegal   <= 1'b0;
            state     <= ST_DONE;
            res_valid <= 1'b1;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
          end
        end
        ST_IDLE: begin
          res_valid <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
